// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the IF/DM requesters, the arbiter and the data SRAM.
// slave = arbiter side, master = requesters plus SRAM side.
interface sram_port_arbiter_if;
  logic        if_req_valid;
  logic [15:0] if_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;

  logic        dm_req_valid;
  logic        dm_we;
  logic [1:0]  dm_size;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_req_ready;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_data;
  logic        dm_rsp_err;

  logic [3:0]  sram_w_en;
  logic [15:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  dm_req_valid, dm_we, dm_size, dm_addr, dm_wdata,
    output dm_req_ready, dm_rsp_valid, dm_rsp_data, dm_rsp_err,
    output sram_w_en, sram_address, sram_write_data,
    input  sram_read_data
  );

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output dm_req_valid, dm_we, dm_size, dm_addr, dm_wdata,
    input  dm_req_ready, dm_rsp_valid, dm_rsp_data, dm_rsp_err,
    input  sram_w_en, sram_address, sram_write_data,
    output sram_read_data
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Single-port data SRAM arbiter: DM has priority, IF is force-granted
// after STARVE_LIMIT denied cycles. Responses are registered, latency 1.
module sram_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  sram_port_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  r_starve_cnt;
  logic        r_if_rsp_valid;
  logic        r_if_rsp_err;
  logic [31:0] r_if_rsp_data;
  logic        r_dm_rsp_valid;
  logic        r_dm_rsp_err;
  logic [31:0] r_dm_rsp_data;

  logic        w_force_if;
  logic        w_dm_gnt;
  logic        w_if_gnt;
  logic [2:0]  w_dm_nbytes;
  logic [3:0]  w_dm_mask;
  logic [16:0] w_dm_end;
  logic        w_dm_err;
  logic        w_if_err;

  always_comb begin
    w_dm_nbytes = 3'd0;
    w_dm_mask   = 4'b0000;
    case (bus.dm_size)
      2'b00: begin
        w_dm_nbytes = 3'd1;
        w_dm_mask   = 4'b0001;
      end
      2'b01: begin
        w_dm_nbytes = 3'd2;
        w_dm_mask   = 4'b0011;
      end
      2'b10: begin
        w_dm_nbytes = 3'd4;
        w_dm_mask   = 4'b1111;
      end
      default: begin
        w_dm_nbytes = 3'd0;
        w_dm_mask   = 4'b0000;
      end
    endcase
  end

  // 17-bit end address so a run past 0xFFFF is caught, not wrapped
  assign w_dm_end = {1'b0, bus.dm_addr}
                  + {14'd0, w_dm_nbytes}
                  - 17'd1;
  assign w_dm_err = (bus.dm_size == 2'b11)
                 || (w_dm_end > 17'h0FFFF);
  assign w_if_err = (bus.if_addr[1:0] != 2'b00)
                 || (bus.if_addr > 16'hFFFC);

  assign w_force_if = bus.if_req_valid
                   && (r_starve_cnt >= LIMIT);
  assign w_dm_gnt = !rst && bus.dm_req_valid
                 && !w_force_if;
  assign w_if_gnt = !rst && bus.if_req_valid
                 && !w_dm_gnt;

  assign bus.if_req_ready = w_if_gnt;
  assign bus.dm_req_ready = w_dm_gnt;

  assign bus.sram_address = w_dm_gnt ? bus.dm_addr
                                     : bus.if_addr;
  assign bus.sram_write_data = bus.dm_wdata;
  assign bus.sram_w_en =
    (w_dm_gnt && bus.dm_we && !w_dm_err)
      ? w_dm_mask : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt   <= 4'd0;
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_err   <= 1'b0;
      r_if_rsp_data  <= 32'd0;
      r_dm_rsp_valid <= 1'b0;
      r_dm_rsp_err   <= 1'b0;
      r_dm_rsp_data  <= 32'd0;
    end else begin
      r_if_rsp_valid <= w_if_gnt;
      r_if_rsp_err   <= w_if_gnt && w_if_err;
      r_dm_rsp_valid <= w_dm_gnt;
      r_dm_rsp_err   <= w_dm_gnt && w_dm_err;
      if (w_if_gnt)
        r_if_rsp_data <= w_if_err ? 32'd0
                                  : bus.sram_read_data;
      if (w_dm_gnt)
        r_dm_rsp_data <= w_dm_err ? 32'd0
                                  : bus.sram_read_data;
      if (!bus.if_req_valid || w_if_gnt)
        r_starve_cnt <= 4'd0;
      else if (r_starve_cnt != 4'd15)
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  assign bus.if_rsp_valid = r_if_rsp_valid;
  assign bus.if_rsp_err   = r_if_rsp_err;
  assign bus.if_rsp_data  = r_if_rsp_data;
  assign bus.dm_rsp_valid = r_dm_rsp_valid;
  assign bus.dm_rsp_err   = r_dm_rsp_err;
  assign bus.dm_rsp_data  = r_dm_rsp_data;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM byte model, vector table,
// corner sequences and random traffic against a reference model.
module tb_sram_port_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter_if bus();

  sram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [7:0] init_byte(int a);
    if (a >= 16 && a <= 19) return 8'(8'h11 * (a - 15));
    return 8'(a);
  endfunction

  // SRAM: byte array, combinational read, byte-enabled write
  logic [7:0] mem [0:65535];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_byte(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.sram_w_en[b])
          mem[bus.sram_address + 16'(b)] <=
            bus.sram_write_data[8*b +: 8];
    end
  end

  assign bus.sram_read_data = {mem[bus.sram_address + 16'd3],
                               mem[bus.sram_address + 16'd2],
                               mem[bus.sram_address + 16'd1],
                               mem[bus.sram_address]};

  // Reference model state
  logic [7:0]  ref_mem [0:65535];
  int          m_starve = 0;
  bit          g_if, g_dm;
  bit          m_if_rv, m_dm_rv, m_if_err, m_dm_err;
  logic [31:0] m_if_data, m_dm_data;

  function automatic logic [31:0] ref_word(int a);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < 4; i++)
      w[8*i +: 8] = ref_mem[(a + i) % 65536];
    return w;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock with the inputs already applied after a negedge.
  task automatic cycle();
    int nb;
    int a;
    bit derr, ierr;
    logic [3:0] wen;
    #1;
    case (bus.dm_size)
      2'd0: nb = 1;
      2'd1: nb = 2;
      2'd2: nb = 4;
      default: nb = 0;
    endcase
    derr = (bus.dm_size == 2'd3) || (int'(bus.dm_addr) + nb - 1 > 65535);
    ierr = (int'(bus.if_addr) % 4 != 0) || (int'(bus.if_addr) > 65532);
    if (rst) begin
      g_dm = 0;
      g_if = 0;
    end else begin
      g_dm = bus.dm_req_valid && !(bus.if_req_valid && m_starve >= LIMIT);
      g_if = bus.if_req_valid && !g_dm;
    end
    wen = (g_dm && bus.dm_we && !derr) ? 4'((1 << nb) - 1) : 4'd0;
    chk("if_req_ready", 32'(bus.if_req_ready), 32'(g_if));
    chk("dm_req_ready", 32'(bus.dm_req_ready), 32'(g_dm));
    chk("sram_w_en", 32'(bus.sram_w_en), 32'(wen));
    chk("sram_address", 32'(bus.sram_address),
        32'(g_dm ? bus.dm_addr : bus.if_addr));
    if (wen != 4'd0)
      chk("sram_write_data", bus.sram_write_data, bus.dm_wdata);
    @(posedge clk);
    if (rst) begin
      {m_if_rv, m_dm_rv, m_if_err, m_dm_err} = 4'd0;
      m_if_data = 32'd0;
      m_dm_data = 32'd0;
      m_starve = 0;
    end else begin
      m_if_rv = g_if;
      m_dm_rv = g_dm;
      m_if_err = g_if && ierr;
      m_dm_err = g_dm && derr;
      if (g_if) m_if_data = ierr ? 32'd0 : ref_word(int'(bus.if_addr));
      if (g_dm) begin
        a = int'(bus.dm_addr);
        m_dm_data = derr ? 32'd0 : ref_word(a);
        if (wen != 4'd0)
          for (int b = 0; b < nb; b++)
            ref_mem[(a + b) % 65536] = bus.dm_wdata[8*b +: 8];
      end
      if (!bus.if_req_valid || g_if) m_starve = 0;
      else if (m_starve < 15) m_starve++;
    end
    #1;
    chk("if_rsp_valid", 32'(bus.if_rsp_valid), 32'(m_if_rv));
    chk("dm_rsp_valid", 32'(bus.dm_rsp_valid), 32'(m_dm_rv));
    chk("if_rsp_err", 32'(bus.if_rsp_err), 32'(m_if_err));
    chk("dm_rsp_err", 32'(bus.dm_rsp_err), 32'(m_dm_err));
    chk("if_rsp_data", bus.if_rsp_data, m_if_data);
    chk("dm_rsp_data", bus.dm_rsp_data, m_dm_data);
    @(negedge clk);
  endtask

  task automatic drive(bit r, bit ifv, logic [15:0] ifa, bit dmv, bit we,
                       logic [1:0] sz, logic [15:0] dma, logic [31:0] wd);
    rst = r;
    bus.if_req_valid = ifv;
    bus.if_addr = ifa;
    bus.dm_req_valid = dmv;
    bus.dm_we = we;
    bus.dm_size = sz;
    bus.dm_addr = dma;
    bus.dm_wdata = wd;
  endtask

  typedef struct {
    bit          r;
    bit          ifv;
    logic [15:0] ifa;
    bit          dmv;
    bit          we;
    logic [1:0]  sz;
    logic [15:0] dma;
    logic [31:0] wd;
    bit          e_ifr;
    bit          e_dmr;
    logic [3:0]  e_wen;
    int          e_port;
    bit          e_err;
    logic [31:0] e_data;
  } vec_t;

  vec_t tv [13];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
    tv[0]  = '{1,1,16'h0000,1,1,2'd2,16'h0200,32'hDEADBEEF,0,0,4'h0,0,0,32'h0};
    tv[1]  = '{0,1,16'h0010,0,0,2'd2,16'h0000,32'h0,1,0,4'h0,1,0,32'h44332211};
    tv[2]  = '{0,0,16'h0000,1,1,2'd1,16'h0101,32'hAABBCCDD,0,1,4'h3,2,0,32'h04030201};
    tv[3]  = '{0,0,16'h0000,1,0,2'd2,16'h0100,32'h0,0,1,4'h0,2,0,32'h03CCDD00};
    tv[4]  = '{0,0,16'h0000,1,1,2'd2,16'hFFFE,32'h12345678,0,1,4'h0,2,1,32'h0};
    tv[5]  = '{0,0,16'h0000,1,1,2'd3,16'h0000,32'h12345678,0,1,4'h0,2,1,32'h0};
    tv[6]  = '{0,1,16'h0002,0,0,2'd0,16'h0000,32'h0,1,0,4'h0,1,1,32'h0};
    tv[7]  = '{0,1,16'hFFFD,0,0,2'd0,16'h0000,32'h0,1,0,4'h0,1,1,32'h0};
    tv[8]  = '{0,1,16'hFFFC,0,0,2'd0,16'h0000,32'h0,1,0,4'h0,1,0,32'hFFFEFDFC};
    tv[9]  = '{0,0,16'h0000,1,1,2'd0,16'hFFFF,32'h12345677,0,1,4'h1,2,0,32'h020100FF};
    tv[10] = '{0,0,16'h0000,1,0,2'd0,16'hFFFF,32'h0,0,1,4'h0,2,0,32'h02010077};
    tv[11] = '{0,1,16'h0020,1,0,2'd2,16'h0010,32'h0,0,1,4'h0,2,0,32'h44332211};
    tv[12] = '{0,1,16'h0020,0,0,2'd2,16'h0010,32'h0,1,0,4'h0,1,0,32'h23222120};

    drive(1, 0, 16'h0, 0, 0, 2'd0, 16'h0, 32'h0);
    @(negedge clk);
    preload = 1'b0;
    cycle();
    chk("reset if_rsp_data", bus.if_rsp_data, 32'h0);
    chk("reset dm_rsp_valid", 32'(bus.dm_rsp_valid), 32'h0);

    for (int k = 0; k < 13; k++) begin
      drive(tv[k].r, tv[k].ifv, tv[k].ifa, tv[k].dmv, tv[k].we,
            tv[k].sz, tv[k].dma, tv[k].wd);
      #1;
      chk($sformatf("tv%0d if_ready", k), 32'(bus.if_req_ready), 32'(tv[k].e_ifr));
      chk($sformatf("tv%0d dm_ready", k), 32'(bus.dm_req_ready), 32'(tv[k].e_dmr));
      chk($sformatf("tv%0d w_en", k), 32'(bus.sram_w_en), 32'(tv[k].e_wen));
      cycle();
      chk($sformatf("tv%0d if_rv", k), 32'(bus.if_rsp_valid), 32'(tv[k].e_port == 1));
      chk($sformatf("tv%0d dm_rv", k), 32'(bus.dm_rsp_valid), 32'(tv[k].e_port == 2));
      if (tv[k].e_port == 1) begin
        chk($sformatf("tv%0d if_err", k), 32'(bus.if_rsp_err), 32'(tv[k].e_err));
        chk($sformatf("tv%0d if_data", k), bus.if_rsp_data, tv[k].e_data);
      end
      if (tv[k].e_port == 2) begin
        chk($sformatf("tv%0d dm_err", k), 32'(bus.dm_rsp_err), 32'(tv[k].e_err));
        chk($sformatf("tv%0d dm_data", k), bus.dm_rsp_data, tv[k].e_data);
      end
    end
    chk("mem FFFC word", {mem[16'hFFFF], mem[16'hFFFE], mem[16'hFFFD], mem[16'hFFFC]},
        32'h77FEFDFC);

    // Starvation: DM x4, IF on the 5th, repeating
    drive(0, 0, 16'h0, 0, 0, 2'd0, 16'h0, 32'h0);
    cycle();
    drive(0, 1, 16'h0020, 1, 0, 2'd2, 16'h0010, 32'h0);
    for (int k = 0; k < 15; k++) begin
      #1;
      chk($sformatf("starve%0d if_ready", k), 32'(bus.if_req_ready), 32'(k % 5 == 4));
      chk($sformatf("starve%0d dm_ready", k), 32'(bus.dm_req_ready), 32'(k % 5 != 4));
      cycle();
    end

    // Reset in the middle of a store burst
    drive(0, 0, 16'h0, 1, 1, 2'd2, 16'h0300, 32'hCAFEF00D);
    cycle();
    chk("pre-rst dm_rv", 32'(bus.dm_rsp_valid), 32'h1);
    drive(1, 0, 16'h0, 1, 1, 2'd2, 16'h0304, 32'h11112222);
    #1;
    chk("rst dm_ready", 32'(bus.dm_req_ready), 32'h0);
    chk("rst w_en", 32'(bus.sram_w_en), 32'h0);
    cycle();
    chk("post-rst dm_rv", 32'(bus.dm_rsp_valid), 32'h0);
    chk("post-rst if_rv", 32'(bus.if_rsp_valid), 32'h0);
    chk("rst no write", {mem[16'h0307], mem[16'h0306], mem[16'h0305], mem[16'h0304]},
        32'h07060504);
    drive(0, 0, 16'h0, 1, 0, 2'd2, 16'h0300, 32'h0);
    cycle();
    chk("resume dm_data", bus.dm_rsp_data, 32'hCAFEF00D);
    chk("resume dm_rv", 32'(bus.dm_rsp_valid), 32'h1);

    // Random traffic; ungranted requests are held stable
    for (int n = 0; n < 500; n++) begin
      logic [31:0] r;
      r = $urandom;
      rst = (r[5:0] == 6'd0);
      if (!bus.if_req_valid || g_if) begin
        bus.if_req_valid = (r[9:8] != 2'd0);
        if (r[12:10] == 3'd0)
          bus.if_addr = 16'hFFF8 + 16'($urandom_range(0, 7));
        else if (r[15:13] == 3'd0)
          bus.if_addr = 16'($urandom_range(0, 63));
        else
          bus.if_addr = 16'($urandom_range(0, 15) * 4);
      end
      if (!bus.dm_req_valid || g_dm) begin
        bus.dm_req_valid = (r[17:16] != 2'd0);
        bus.dm_we = r[18];
        bus.dm_size = (r[22:19] == 4'd0) ? 2'd3 : 2'($urandom_range(0, 2));
        bus.dm_addr = (r[25:23] == 3'd0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                         : 16'($urandom_range(0, 63));
        bus.dm_wdata = $urandom;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single-port, byte-addressed data SRAM between the instruction-fetch (IF) and data-memory (DM) requesters of the pipeline CPU.
- DM has fixed priority. A starvation counter guarantees IF forward progress.
- Generates the 4-bit byte write enable from the access size, range-checks each access, and returns registered responses one cycle after grant.
- The SRAM interface is a 16-bit byte address, a 4-bit byte write enable, 32-bit write data, and a combinational 32-bit read of bytes addr..addr+3 (LSB = byte at addr).

Parameters:
STARVE_LIMIT, 4, consecutive cycles IF may be denied while requesting before it is force-granted (1..15).

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
if_req_valid  input  1  IF fetch request
if_addr  input  16  IF byte address
if_req_ready  output  1  IF request granted this cycle
if_rsp_valid  output  1  IF response pulse
if_rsp_data  output  32  fetched word
if_rsp_err  output  1  IF access rejected
dm_req_valid  input  1  DM request
dm_we  input  1  1 = store, 0 = load
dm_size  input  2  00 byte, 01 half, 10 word, 11 illegal
dm_addr  input  16  DM byte address
dm_wdata  input  32  store data, LSB-aligned
dm_req_ready  output  1  DM request granted this cycle
dm_rsp_valid  output  1  DM response pulse
dm_rsp_data  output  32  word read at dm_addr (pre-write contents for stores)
dm_rsp_err  output  1  DM access rejected
sram_w_en  output  4  byte write enables to SRAM
sram_address  output  16  SRAM byte address
sram_write_data  output  32  SRAM write data
sram_read_data  input  32  SRAM combinational read data

Behaviour:
- Clock is clk; reset rst is synchronous, active-high.
- Reset values: if_rsp_valid=0, dm_rsp_valid=0, if_rsp_err=0, dm_rsp_err=0, if_rsp_data=0, dm_rsp_data=0, starve_cnt=0.
- While rst=1: if_req_ready=0, dm_req_ready=0, sram_w_en=0. No SRAM write can occur in a reset cycle.

Grant (combinational, one grant per cycle):
- force_if = if_req_valid && starve_cnt >= STARVE_LIMIT.
- Grant DM when dm_req_valid && !force_if.
- Otherwise grant IF when if_req_valid.
- Ready is asserted only for the granted requester, in the same cycle as its valid. A request that is not granted must be held stable by the requester until it is granted.

Starvation counter:
- Increments (saturating at 15) each cycle IF is valid but not granted.
- Cleared when IF is granted or when if_req_valid=0.

SRAM drive (combinational, in the grant cycle):
- sram_address = granted address. When idle, sram_address = if_addr.
- sram_write_data = dm_wdata.
- sram_w_en = 0 unless DM is granted, dm_we=1, and there is no error. Then it is 0001 for byte, 0011 for half, 1111 for word.
- Misaligned DM addresses are legal. IF requires if_addr[1:0]=00.

Range and legality checks (evaluated in the grant cycle):
- DM error when dm_size=11, or dm_addr + nbytes - 1 > 0xFFFF (nbytes = 1/2/4). Compute with 17-bit arithmetic; no wrap-around.
- IF error when if_addr[1:0]!=0 or if_addr > 0xFFFC.
- An erroring request still consumes its grant. sram_w_en stays 0, and the response carries err=1 with data=0.

Response (latency 1):
- At the grant edge, sram_read_data (or 0 on error) is registered into the granted port's rsp_data.
- rsp_valid pulses high for exactly one cycle after the grant cycle. rsp_err is registered alongside it.
- Stores also produce a response; its data is the contents before the write.
- The non-granted port's rsp_valid is 0 that cycle. The rsp_data registers hold their value when not updated.

Back-to-back operation:
- Back-to-back grants are allowed every cycle.
- Read-after-write to the same address in the next cycle returns the new data.

Reset mid-operation:
- Any grant in the cycle where rst rises is cancelled.
- No response is issued for a request granted in the cycle before reset if reset suppresses its response edge, because rsp_valid is cleared by rst.

Test Plan:
- Reset, then IF-only fetch of 0x0010 with SRAM bytes 0x10..0x13 = 11,22,33,44 -> if_req_ready=1 in the same cycle; next cycle if_rsp_valid=1, if_rsp_data=0x44332211.
- DM half store: addr 0x0101, wdata 0xAABBCCDD -> sram_w_en=0011, bytes 0x101=DD and 0x102=CC; next-cycle load word at 0x0100 sees new bytes; dm_rsp_valid pulses once per access.
- IF and DM valid continuously with STARVE_LIMIT=4 -> DM granted 4 cycles, IF granted on the 5th, then DM again; the pattern repeats and starve_cnt never exceeds 4.
- DM word store at 0xFFFE, and dm_size=11 at 0x0000 -> each gets dm_rsp_err=1 with data 0, sram_w_en=0000, memory unchanged.
- IF fetch at 0x0002 and at 0xFFFD -> if_rsp_err=1 on each, one cycle after its grant.
- Assert rst for one cycle while a DM word store is valid -> no SRAM write, dm_req_ready=0, all rsp_valid=0 in the following cycle; normal operation resumes after rst falls.
